// File: rtl/home_status_tx.sv
// Serial status transmitter to the remote wall panel: start bit, 9 payload bits LSB first,
// even parity, stop bit. A frame is sent when the sampled word changes or on a resend request.
//
// state    | meaning
// ---------+----------------------------------------------
// S_IDLE   | line high, waiting for a payload change or request
// S_START  | driving the start bit (0)
// S_DATA   | driving payload bits 0..8 from the shift register
// S_PARITY | driving the even parity of the latched payload
// S_STOP   | driving the stop bit (1); done in its last cycle
module home_status_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [2:0] display,
    input  logic       fdoor,
    input  logic       rdoor,
    input  logic       winbuzz,
    input  logic       alarmbuzz,
    input  logic       heater,
    input  logic       cooler,
    input  logic       send_req,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [7:0] BAUD_MAX = 8'(CLKS_PER_BIT - 1);

    state_t     r_state,  w_state_nx;
    logic [7:0] r_baud,   w_baud_nx;
    logic [3:0] r_bit,    w_bit_nx;
    logic [8:0] r_shift,  w_shift_nx;
    logic       r_par,    w_par_nx;
    logic [8:0] r_last,   w_last_nx;
    logic       r_pend,   w_pend_nx;
    logic [7:0] r_cnt,    w_cnt_nx;
    logic       r_tx,     w_tx_nx;
    logic       r_busy,   w_busy_nx;
    logic       r_done,   w_done_nx;
    logic [8:0] w_payload;

    assign w_payload = {cooler, heater, alarmbuzz, winbuzz, rdoor, fdoor, display};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_last  <= '0;
            r_pend  <= 1'b0;
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_baud  <= w_baud_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_par   <= w_par_nx;
            r_last  <= w_last_nx;
            r_pend  <= w_pend_nx;
            r_cnt   <= w_cnt_nx;
            r_tx    <= w_tx_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_baud_nx  = r_baud;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_par_nx   = r_par;
        w_last_nx  = r_last;
        w_pend_nx  = r_pend | send_req;
        w_cnt_nx   = r_cnt;

        case (r_state)
            S_IDLE: begin
                // A request arriving with the change is absorbed into this same frame.
                if ((w_payload != r_last) || r_pend || send_req) begin
                    w_state_nx = S_START;
                    w_baud_nx  = BAUD_MAX;
                    w_bit_nx   = '0;
                    w_shift_nx = w_payload;
                    w_par_nx   = ^w_payload;
                    w_last_nx  = w_payload;
                    w_pend_nx  = 1'b0;
                end
            end
            S_START: begin
                if (r_baud == 8'd0) begin
                    w_state_nx = S_DATA;
                    w_baud_nx  = BAUD_MAX;
                    w_bit_nx   = '0;
                end else begin
                    w_baud_nx = r_baud - 8'd1;
                end
            end
            S_DATA: begin
                if (r_baud == 8'd0) begin
                    w_baud_nx = BAUD_MAX;
                    if (r_bit == 4'd8) begin
                        w_state_nx = S_PARITY;
                        w_bit_nx   = '0;
                    end else begin
                        w_bit_nx   = r_bit + 4'd1;
                        w_shift_nx = {1'b0, r_shift[8:1]};
                    end
                end else begin
                    w_baud_nx = r_baud - 8'd1;
                end
            end
            S_PARITY: begin
                if (r_baud == 8'd0) begin
                    w_state_nx = S_STOP;
                    w_baud_nx  = BAUD_MAX;
                end else begin
                    w_baud_nx = r_baud - 8'd1;
                end
            end
            S_STOP: begin
                if (r_baud == 8'd0) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = r_cnt + 8'd1;
                end else begin
                    w_baud_nx = r_baud - 8'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_baud_nx  = '0;
                w_bit_nx   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with it.
        case (w_state_nx)
            S_START:  w_tx_nx = 1'b0;
            S_DATA:   w_tx_nx = w_shift_nx[0];
            S_PARITY: w_tx_nx = w_par_nx;
            default:  w_tx_nx = 1'b1;
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
        w_done_nx = (w_state_nx == S_STOP) && (w_baud_nx == 8'd0);
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign frame_cnt = r_cnt;

endmodule

// File: tb/tb_home_status_tx.sv
// Bench for home_status_tx: frames captured from the serial line are compared with frames
// built from the payload word, and frame counts with a software tally of expected frames.
module tb_home_status_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 12 * CPB;

    logic       Clk;
    logic       Rst_n;
    logic [2:0] display;
    logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler;
    logic       send_req;
    logic       tx, busy, done;
    logic [7:0] frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] cur;
    logic [8:0] m_last;
    logic [7:0] m_cnt;

    logic [11:0] c_bits;
    int          c_lat, c_nbusy, c_ndone, c_done_idx;
    bit          c_held, c_got;
    logic        c_after;

    home_status_tx #(.CLKS_PER_BIT(CPB)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .display(display), .fdoor(fdoor), .rdoor(rdoor),
        .winbuzz(winbuzz), .alarmbuzz(alarmbuzz), .heater(heater), .cooler(cooler),
        .send_req(send_req), .tx(tx), .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Line order: bit 0 is the start bit, then payload LSB first, parity, stop.
    function automatic logic [11:0] model_frame(input logic [8:0] p);
        return {1'b1, ^p, p, 1'b0};
    endfunction

    task automatic set_payload(input logic [8:0] p);
        cur       = p;
        display   = p[2:0];
        fdoor     = p[3];
        rdoor     = p[4];
        winbuzz   = p[5];
        alarmbuzz = p[6];
        heater    = p[7];
        cooler    = p[8];
    endtask

    // Called at a falling edge. Waits for busy, samples a full frame, then one cycle after it.
    task automatic capture(input bit req0, input int req_at, input int chg_at,
                           input logic [8:0] chg_p, input int chg2_at,
                           input logic [8:0] chg2_p, input int budget);
        c_got = 0; c_lat = 0; c_nbusy = 0; c_ndone = 0; c_done_idx = -1;
        c_held = 1; c_bits = '0; c_after = 1'b1;
        send_req = req0;
        while (!c_got && c_lat < budget) begin
            @(negedge Clk);
            send_req = 1'b0;
            if (busy === 1'b1) c_got = 1;
            else c_lat++;
        end
        if (!c_got) return;
        for (int c = 1; c <= FRAME; c++) begin
            if (c > 1) @(negedge Clk);
            if (busy === 1'b1) c_nbusy++;
            if (done === 1'b1) begin
                c_ndone++;
                c_done_idx = c;
            end
            if ((c - 1) % CPB == 0) c_bits[(c - 1) / CPB] = tx;
            else if (tx !== c_bits[(c - 1) / CPB]) c_held = 0;
            send_req = (c == req_at);
            if (c == chg_at)  set_payload(chg_p);
            if (c == chg2_at) set_payload(chg2_p);
        end
        @(negedge Clk);
        send_req = 1'b0;
        c_after  = busy;
        if (done === 1'b1) c_ndone++;
    endtask

    task automatic test_reset();
        int bad_idle;
        Rst_n = 1'b0;
        send_req = 1'b0;
        set_payload(9'h000);
        repeat (3) @(negedge Clk);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
        Rst_n  = 1'b1;
        m_last = 9'h000;
        m_cnt  = 8'd0;
        bad_idle = 0;
        repeat (100) begin
            @(negedge Clk);
            if (busy !== 1'b0 || tx !== 1'b1 || frame_cnt !== 8'd0) bad_idle++;
        end
        n_cmp++; if (bad_idle != 0) begin n_bad++; $display("FAIL idle_100: got %0d active cycles want 0", bad_idle); end
    endtask

    task automatic test_single_frame();
        logic [11:0] spec_seq;
        spec_seq = 12'b1101_0000_1010;
        set_payload(9'h085);
        capture(0, -1, -1, 9'h0, -1, 9'h0, 20);
        m_cnt++; m_last = 9'h085;
        n_cmp++; if (c_got != 1) begin n_bad++; $display("FAIL single_got: got %0d want 1", c_got); end
        n_cmp++; if (c_lat != 0) begin n_bad++; $display("FAIL single_latency: got %0d want 0", c_lat); end
        n_cmp++; if (c_bits !== model_frame(9'h085)) begin n_bad++; $display("FAIL single_bits: got %b want %b", c_bits, model_frame(9'h085)); end
        n_cmp++; if (c_bits !== spec_seq) begin n_bad++; $display("FAIL single_seq: got %b want %b", c_bits, spec_seq); end
        n_cmp++; if (c_held != 1) begin n_bad++; $display("FAIL single_hold: got %0d want 1", c_held); end
        n_cmp++; if (c_nbusy != FRAME) begin n_bad++; $display("FAIL single_busy_len: got %0d want %0d", c_nbusy, FRAME); end
        n_cmp++; if (c_ndone != 1 || c_done_idx != FRAME) begin n_bad++; $display("FAIL single_done: got %0d pulses at %0d want 1 at %0d", c_ndone, c_done_idx, FRAME); end
        n_cmp++; if (c_after !== 1'b0) begin n_bad++; $display("FAIL single_busy_fall: got %b want 0", c_after); end
        n_cmp++; if (frame_cnt !== m_cnt) begin n_bad++; $display("FAIL single_cnt: got %0d want %0d", frame_cnt, m_cnt); end
    endtask

    task automatic test_mid_frame_change();
        capture(1, -1, 5 * CPB + 1, 9'h185, -1, 9'h0, 20);
        m_cnt++; m_last = 9'h085;
        n_cmp++; if (c_bits !== model_frame(9'h085)) begin n_bad++; $display("FAIL mid_first_bits: got %b want %b", c_bits, model_frame(9'h085)); end
        n_cmp++; if (c_after !== 1'b0) begin n_bad++; $display("FAIL mid_idle_gap: got busy %b want 0", c_after); end
        capture(0, -1, -1, 9'h0, -1, 9'h0, 20);
        m_cnt++; m_last = 9'h185;
        n_cmp++; if (c_got != 1 || c_lat != 0) begin n_bad++; $display("FAIL mid_second_start: got %0d lat %0d want 1 lat 0", c_got, c_lat); end
        n_cmp++; if (c_bits !== model_frame(9'h185)) begin n_bad++; $display("FAIL mid_second_bits: got %b want %b", c_bits, model_frame(9'h185)); end
        n_cmp++; if (frame_cnt !== m_cnt) begin n_bad++; $display("FAIL mid_cnt: got %0d want %0d", frame_cnt, m_cnt); end
    endtask

    task automatic test_forced_resend();
        set_payload(9'h085);
        capture(0, -1, -1, 9'h0, -1, 9'h0, 20);
        m_cnt++; m_last = 9'h085;
        n_cmp++; if (c_bits !== model_frame(9'h085)) begin n_bad++; $display("FAIL resend_pre_bits: got %b want %b", c_bits, model_frame(9'h085)); end
        capture(1, 10, -1, 9'h0, -1, 9'h0, 20);
        m_cnt++;
        n_cmp++; if (c_got != 1 || c_bits !== model_frame(9'h085)) begin n_bad++; $display("FAIL resend_a: got %0d %b want 1 %b", c_got, c_bits, model_frame(9'h085)); end
        capture(0, -1, -1, 9'h0, -1, 9'h0, 20);
        m_cnt++;
        n_cmp++; if (c_got != 1 || c_lat != 0) begin n_bad++; $display("FAIL resend_b_start: got %0d lat %0d want 1 lat 0", c_got, c_lat); end
        n_cmp++; if (c_bits !== model_frame(9'h085)) begin n_bad++; $display("FAIL resend_b_bits: got %b want %b", c_bits, model_frame(9'h085)); end
        capture(0, -1, -1, 9'h0, -1, 9'h0, 60);
        n_cmp++; if (c_got != 0) begin n_bad++; $display("FAIL resend_extra: got %0d frames want 0", c_got); end
        n_cmp++; if (frame_cnt !== m_cnt) begin n_bad++; $display("FAIL resend_cnt: got %0d want %0d", frame_cnt, m_cnt); end
    endtask

    task automatic test_glitch();
        capture(1, -1, 10, 9'h08D, 30, 9'h085, 20);
        m_cnt++;
        n_cmp++; if (c_bits !== model_frame(9'h085)) begin n_bad++; $display("FAIL glitch_bits: got %b want %b", c_bits, model_frame(9'h085)); end
        capture(0, -1, -1, 9'h0, -1, 9'h0, 60);
        n_cmp++; if (c_got != 0) begin n_bad++; $display("FAIL glitch_extra: got %0d frames want 0", c_got); end
        n_cmp++; if (frame_cnt !== m_cnt) begin n_bad++; $display("FAIL glitch_cnt: got %0d want %0d", frame_cnt, m_cnt); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            logic [8:0] p, q;
            bit         req;
            int         chg;
            p   = 9'($urandom_range(0, 511));
            q   = 9'($urandom_range(0, 511));
            req = ($urandom_range(0, 1) == 1);
            if (p == m_last) req = 1;
            chg = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, FRAME - 1)) : -1;
            set_payload(p);
            capture(req, -1, chg, q, -1, 9'h0, 20);
            m_cnt++; m_last = p;
            n_cmp++; if (c_got != 1 || c_bits !== model_frame(p)) begin n_bad++; $display("FAIL rand_bits[%0d]: got %0d %b want 1 %b", it, c_got, c_bits, model_frame(p)); end
            if (chg > 0 && q != p) begin
                capture(0, -1, -1, 9'h0, -1, 9'h0, 20);
                m_cnt++; m_last = q;
                n_cmp++; if (c_got != 1 || c_bits !== model_frame(q)) begin n_bad++; $display("FAIL rand_follow[%0d]: got %0d %b want 1 %b", it, c_got, c_bits, model_frame(q)); end
            end
            n_cmp++; if (frame_cnt !== m_cnt) begin n_bad++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", it, frame_cnt, m_cnt); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] start;
        int         missed;
        start  = m_cnt;
        missed = 0;
        for (int i = 0; i < 256; i++) begin
            capture(1, -1, -1, 9'h0, -1, 9'h0, 20);
            if (c_got != 1) missed++;
            m_cnt++;
            if (m_cnt == 8'd0) begin
                n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_zero: got %0d want 0", frame_cnt); end
            end
        end
        n_cmp++; if (missed != 0) begin n_bad++; $display("FAIL wrap_frames: got %0d missing want 0", missed); end
        n_cmp++; if (frame_cnt !== start) begin n_bad++; $display("FAIL wrap_cnt: got %0d want %0d", frame_cnt, start); end
    endtask

    task automatic test_reset_mid_frame();
        int n_done;
        send_req = 1'b1;
        @(negedge Clk);
        send_req = 1'b0;
        repeat (41) @(negedge Clk);
        n_cmp++; if (busy !== 1'b1 || tx !== ^cur) begin n_bad++; $display("FAIL rstmid_parity: got busy %b tx %b want 1 %b", busy, tx, ^cur); end
        Rst_n = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_async: got tx %b busy %b want 1 0", tx, busy); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL rstmid_cnt: got %0d want 0", frame_cnt); end
        n_done = 0;
        repeat (3) begin
            @(negedge Clk);
            if (done !== 1'b0) n_done++;
        end
        n_cmp++; if (n_done != 0) begin n_bad++; $display("FAIL rstmid_done: got %0d pulses want 0", n_done); end
        Rst_n  = 1'b1;
        m_cnt  = 8'd0;
        m_last = 9'h000;
        capture(0, -1, -1, 9'h0, -1, 9'h0, 20);
        m_cnt++; m_last = cur;
        n_cmp++; if (c_got != 1 || c_bits !== model_frame(cur)) begin n_bad++; $display("FAIL rstmid_frame: got %0d %b want 1 %b", c_got, c_bits, model_frame(cur)); end
        n_cmp++; if (c_ndone != 1 || c_nbusy != FRAME) begin n_bad++; $display("FAIL rstmid_timing: got done %0d busy %0d want 1 %0d", c_ndone, c_nbusy, FRAME); end
        n_cmp++; if (frame_cnt !== m_cnt) begin n_bad++; $display("FAIL rstmid_after_cnt: got %0d want %0d", frame_cnt, m_cnt); end
    endtask

    initial begin
        Rst_n    = 1'b0;
        send_req = 1'b0;
        set_payload(9'h000);
        test_reset();
        test_single_frame();
        test_mid_frame_change();
        test_forced_resend();
        test_glitch();
        test_random();
        test_wrap();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/home_status_tx.md
# home_status_tx

Serial status transmitter for the smart-home controller. Each cycle it samples the controller's actuator commands and 3-bit display code. When that word changes, or when a resend is requested, it sends the word as a framed, parity-protected asynchronous bit stream to the remote wall panel. It sits downstream of the home-control FSM and is the sending end of the panel link, whose receiver lives in the panel.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..255.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- display  in  3  display code from the controller.
- fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler  in  1 each  actuator commands from the controller.
- send_req  in  1  single-cycle pulse; forces one frame carrying the current payload even if unchanged.
- tx  out  1  serial line; idles high.
- busy  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- done  out  1  one-cycle pulse in the final cycle of the stop bit.
- frame_cnt  out  8  count of completed frames; wraps 255 -> 0.

## Operation
- Payload is 9 bits, formed combinationally:
  - [2:0] = display
  - [3] = fdoor
  - [4] = rdoor
  - [5] = winbuzz
  - [6] = alarmbuzz
  - [7] = heater
  - [8] = cooler
- Frame is 12 bit-times: start (0), payload[0]..payload[8] sent LSB first, even parity (XOR of the 9 payload bits), stop (1).
- Internal state:
  - last_sent (9 bits, reset 0): payload of the most recent frame, latched at frame start.
  - req_pend (1 bit, reset 0): set by send_req in any state; cleared when a frame starts.
  - shift register: the payload latched at frame start; inputs that change mid-frame do not affect the frame in flight.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when (payload != last_sent) or req_pend or send_req. On that edge: latch payload into the shift register and last_sent, clear req_pend.
  - START -> DATA, DATA -> PARITY, PARITY -> STOP: each after CLKS_PER_BIT cycles. DATA holds 9 bit slots, tracked by a 4-bit counter running 0..8.
  - STOP -> IDLE after CLKS_PER_BIT cycles. On that edge: frame_cnt increments.
- A payload change during a frame is not lost. Back in IDLE it differs from last_sent, so the next frame is sent.
- A payload that changes and then reverts before IDLE produces no extra frame.
- send_req arriving together with a payload change yields exactly one frame.

## Timing
- Reset values: tx=1, busy=0, done=0, frame_cnt=0, FSM=IDLE, baud and bit counters=0.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously). That frame is abandoned, frame_cnt is not incremented, and no done pulse is produced.
- Latency: trigger condition true in IDLE at edge N -> tx=0 and busy=1 from edge N (registered outputs).
- Each bit is held exactly CLKS_PER_BIT cycles. A whole frame takes 12*CLKS_PER_BIT cycles.
- done is high during the last stop-bit cycle, coincident with busy=1. busy falls on the following edge.
- There is at least 1 IDLE cycle (tx=1, busy=0) between consecutive frames.
- frame_cnt updates on the same edge busy falls.
- tx, busy, done and frame_cnt come directly from flops; there is no combinational path from inputs to outputs.

## Test plan
- Reset and idle: hold Rst_n=0, then release with all inputs 0.
  - -> tx=1, busy=0, frame_cnt=0, and no frame for 100 cycles.
- Single frame with CLKS_PER_BIT=4: set display=3'b101, heater=1 (payload 9'h085, parity 1).
  - -> tx sequence 0,1,0,1,0,0,0,0,1,0,1,1, each held 4 cycles (48 cycles total).
  - -> done pulses at cycle 48, frame_cnt=1.
- Mid-frame change: during the 5th data bit, set cooler=1.
  - -> the current frame is unchanged.
  - -> after 1 idle cycle a second frame with payload 9'h185 and parity 0 is sent; frame_cnt=2.
- Forced resend: payload stable at 9'h085, pulse send_req once while IDLE, then once while busy.
  - -> two identical 9'h085 frames back-to-back, separated by 1 idle cycle; frame_cnt advances by 2.
- Glitch suppression and wrap:
  - Toggle fdoor 1 -> 0 within one frame time while busy -> no extra frame afterward.
  - Run 256 forced frames -> frame_cnt wraps to 0.
- Reset mid-frame: drop Rst_n during the PARITY bit.
  - -> tx=1 in the same cycle, busy=0, frame_cnt=0, no done pulse.
  - -> after release with a nonzero payload, a complete frame follows.
